input_mod: RTL and testbench
============================

Name: input_mod

Overview:
- Input-side peripheral for the single-cycle CPU; it is the counterpart of the seven-segment output module.
- It serves the CPU's input instruction by stalling the PC until the operator sets the switches and presses and releases the push-button.
- It then presents the captured switch word for exactly one cycle so the CPU can write it to a register.
- It contains the button debouncer, the switch/button synchronisers and the request/valid handshake FSM.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable clocks required before the debounced button level changes. Use 4 in simulation.
- SIGN_EXT, 0: 0 zero-extends switches[17:0] to 32 bits; 1 sign-extends from bit 17.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous reset, active-high.
- button, input, 1: raw push-button, active-low (0 = pressed), asynchronous to clock.
- switches, input, 18: raw switch bank, asynchronous to clock.
- in_req, input, 1: CPU is executing an input instruction (decoded inputuse).
- stall, output, 1: freeze the PC and register write.
- data_valid, output, 1: data_out is valid this cycle.
- data_out, output, 32: captured, extended switch word.
- press_count, output, 8: number of completed input transactions; wraps.

Behaviour:
- Reset: asserting reset immediately forces:
  - state = IDLE;
  - stall = 0, data_valid = 0, data_out = 0, press_count = 0;
  - debounce counter = 0;
  - synchroniser flops: button = 1 (released), switches = 0;
  - debounced button = released.
- Synchronisers: two flops on button and on each switch bit. The synchronised value lags the pins by 2 clocks.
- Debounce:
  - The counter increments each clock while the synchronised button differs from the debounced level.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the debounced level toggles on that edge and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never changes the debounced level.
- Debounced events: a press event is a debounced 1->0 transition; a release event is a debounced 0->1 transition. Each event is a single-cycle internal pulse.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: if in_req = 1, go to WAIT_PRESS. A press already in progress does not count.
  - WAIT_PRESS: on a press event, register the synchronised switches (extended per SIGN_EXT) into data_out and go to WAIT_RELEASE.
  - WAIT_RELEASE: on a release event, go to DONE. Switch changes during the hold are ignored.
  - DONE: lasts exactly one cycle. data_valid = 1, stall = 0, press_count increments (255 -> 0). Always returns to IDLE.
  - Abort: if in_req = 0 in WAIT_PRESS or WAIT_RELEASE, return to IDLE. data_out and press_count are unchanged and no data_valid is produced.
- Outputs:
  - stall = in_req AND (state != DONE), combinational. The first in_req cycle therefore stalls with zero latency.
  - data_valid = (state == DONE), registered.
  - data_out holds its last captured value until the next capture.
- Back-to-back input instructions: after DONE the FSM is in IDLE. If in_req is still or again 1, it re-enters WAIT_PRESS and requires a fresh press and release, so one press never satisfies two instructions.
- Button held at request: if the debounced button is already pressed when WAIT_PRESS is entered, no press event occurs. The operator must release and press again.
- Latency: from a clean raw press to capture is 2 + DEBOUNCE_CYCLES clocks, and likewise from release to DONE.
- Reset mid-transaction: the transaction is discarded and the bench must see no data_valid after reset deassertion.

Test Plan (all with DEBOUNCE_CYCLES = 4):
1. Basic input: in_req=1, switches=18'h2A5F3, clean press held 10 clocks then released.
   - stall=1 from the first in_req cycle.
   - data_valid=1 for exactly one cycle, 2+4 clocks after the release.
   - data_out=32'h0002A5F3; press_count=1; stall=0 in that cycle.
2. Bounce rejection: in_req=1, button toggles 0/1 every 2 clocks for 20 clocks, then stays 1.
   - No capture, no data_valid; stall stays 1.
3. Sign extension: SIGN_EXT=1, switches=18'h20001, full press/release.
   - data_out=32'hFFFE0001.
4. Switch change during hold: switches=18'h00011 at the press, changed to 18'h3FFFF before the release.
   - data_out=32'h00000011.
5. Back-to-back and held button: two consecutive in_req transactions with the button still held when the second starts.
   - The second stays stalled until a release followed by a new press and release.
   - press_count goes 1 then 2; data_out updates each time.
6. Reset and abort:
   - Reset asserted during WAIT_RELEASE: all outputs go to 0 immediately and there is no data_valid afterwards.
   - in_req dropped during WAIT_PRESS: FSM returns to IDLE, press_count unchanged.

Source files
------------

// File: rtl/input_mod.sv
// ---------------------------------------------------------------------------
// input_mod
// Input-side peripheral for the single-cycle CPU. While the CPU executes an
// input instruction, this block stalls the PC until the operator sets the
// switches and presses and releases the push-button. It then presents the
// captured switch word for exactly one cycle so the CPU can write it to a
// register.
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous reset, active-high
//   button      - raw push-button, active-low (0 = pressed), asynchronous
//   switches    - raw 18-bit switch bank, asynchronous
//   in_req      - CPU is executing an input instruction
//   stall       - freeze PC and register write
//   data_valid  - data_out is valid this cycle (one cycle per transaction)
//   data_out    - captured switch word, zero- or sign-extended to 32 bits
//   press_count - number of completed input transactions, wraps at 256
// ---------------------------------------------------------------------------
module input_mod #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit SIGN_EXT        = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button,
    input  logic [17:0] switches,
    input  logic        in_req,
    output logic        stall,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic [7:0]  press_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    state_t            state;
    logic              button_p0;
    logic              button_p1;
    logic [17:0]       switches_p0;
    logic [17:0]       switches_p1;
    logic              button_db;
    logic [CNT_W-1:0]  db_cnt;
    logic              db_flip;
    logic              press_evt;
    logic              release_evt;

    function automatic logic [31:0] extend(input logic [17:0] sw);
        if (SIGN_EXT)
            return {{14{sw[17]}}, sw};
        else
            return {14'b0, sw};
    endfunction

    // Stage p0/p1: two-flop synchronisers on the asynchronous pins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            button_p0   <= 1'b1;
            button_p1   <= 1'b1;
            switches_p0 <= '0;
            switches_p1 <= '0;
        end else begin
            button_p0   <= button;
            button_p1   <= button_p0;
            switches_p0 <= switches;
            switches_p1 <= switches_p0;
        end
    end

    // The debounced level flips on the same edge the counter saturates, so
    // press/release events are derived combinationally from that condition
    // and are naturally one cycle wide.
    assign db_flip     = (button_p1 != button_db) && (db_cnt == CNT_MAX);
    assign press_evt   = db_flip && !button_p1;
    assign release_evt = db_flip && button_p1;

    // Debounce: count consecutive cycles of disagreement
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            button_db <= 1'b1;
            db_cnt    <= '0;
        end else if (button_p1 == button_db) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            button_db <= button_p1;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Handshake FSM; data_valid and press_count update on entry to DONE so
    // they line up with the cycle in which state == DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_valid  <= 1'b0;
            data_out    <= '0;
            press_count <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_req)
                        state <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (!in_req) begin
                        state <= IDLE;
                    end else if (press_evt) begin
                        data_out <= extend(switches_p1);
                        state    <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!in_req) begin
                        state <= IDLE;
                    end else if (release_evt) begin
                        data_valid  <= 1'b1;
                        press_count <= press_count + 8'd1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency stall on the first in_req cycle; forced low while in reset.
    assign stall = in_req && !reset && (state != DONE);

endmodule

// File: tb/tb_input_mod.sv
module tb_input_mod;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  cnt;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        button;
    logic [17:0] switches;
    logic        in_req;

    logic        stall0, dv0, stall1, dv1;
    logic [31:0] dout0, dout1;
    logic [7:0]  cnt0, cnt1;

    int total_cnt = 0;
    int bad_cnt   = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  exp_cnt = 8'd0;
    logic [31:0] last0   = 32'd0;
    logic [31:0] last1   = 32'd0;
    logic        dv0_prev = 1'b0;
    logic        dv1_prev = 1'b0;

    input_mod #(.DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b0)) dut0 (
        .clock(clock), .reset(reset), .button(button), .switches(switches),
        .in_req(in_req), .stall(stall0), .data_valid(dv0),
        .data_out(dout0), .press_count(cnt0)
    );

    input_mod #(.DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .button(button), .switches(switches),
        .in_req(in_req), .stall(stall1), .data_valid(dv1),
        .data_out(dout1), .press_count(cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [17:0] sw);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.cnt  = exp_cnt;
        e.data = 32'(sw);
        q0.push_back(e);
        last0 = e.data;
        e.data = sw[17] ? (32'hFFFC0000 | 32'(sw)) : 32'(sw);
        q1.push_back(e);
        last1 = e.data;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (dv0) begin
                n = i;
                break;
            end
        end
    endtask

    // Full transaction; sw_hold is applied to the pins during the hold.
    task automatic do_txn(input logic [17:0] sw, input logic [17:0] sw_hold);
        int n;
        switches = sw;
        tick(3);
        in_req = 1'b1;
        #1;
        chk("stall_first", 32'(stall0), 1);
        tick(1);
        push_exp(sw);
        button = 1'b0;
        tick(10);
        chk("stall_hold", 32'(stall0), 1);
        switches = sw_hold;
        tick(4);
        button = 1'b1;
        wait_valid(n);
        chk("rel_lat", n, 6);
        tick(1);
        in_req = 1'b0;
        tick(2);
    endtask

    // Scoreboard: every data_valid must match the oldest expectation
    always @(negedge clock) begin
        if (dv0) begin
            chk("dv0_len", 32'(dv0_prev), 0);
            chk("stall_done0", 32'(stall0), 0);
            if (q0.size() == 0) begin
                chk("dv0_unexpected", 32'(dv0), 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dout0", dout0, e.data);
                chk("cnt0", 32'(cnt0), 32'(e.cnt));
            end
        end
        if (dv1) begin
            chk("dv1_len", 32'(dv1_prev), 0);
            if (q1.size() == 0) begin
                chk("dv1_unexpected", 32'(dv1), 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dout1", dout1, e.data);
                chk("cnt1", 32'(cnt1), 32'(e.cnt));
            end
        end
        dv0_prev <= dv0;
        dv1_prev <= dv1;
    end

    initial begin
        int n;
        reset    = 1'b1;
        button   = 1'b1;
        switches = 18'h0;
        in_req   = 1'b0;
        #12;
        chk("rst_dv", 32'(dv0), 0);
        chk("rst_dout", dout0, 0);
        chk("rst_cnt", 32'(cnt0), 0);
        in_req = 1'b1;
        #1;
        chk("rst_stall", 32'(stall0), 0);
        in_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(3);

        // Basic input
        do_txn(18'h2A5F3, 18'h2A5F3);
        chk("basic_hold0", dout0, 32'h0002A5F3);
        chk("basic_cnt", 32'(cnt0), 1);

        // Bounce rejection
        in_req = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            button = 1'b0;
            tick(2);
            button = 1'b1;
            tick(2);
            chk("bounce_stall", 32'(stall0), 1);
        end
        tick(10);
        chk("bounce_stall_end", 32'(stall0), 1);
        chk("bounce_dout", dout0, last0);
        chk("bounce_cnt", 32'(cnt0), 32'(exp_cnt));
        in_req = 1'b0;
        tick(2);

        // Sign extension (dut1 checked by scoreboard)
        do_txn(18'h20001, 18'h20001);
        chk("sext_dout1", dout1, 32'hFFFE0001);

        // Switch change during hold
        do_txn(18'h00011, 18'h3FFFF);
        chk("hold_change", dout0, 32'h00000011);

        // Back-to-back with button held at request
        button = 1'b0;
        tick(10);
        switches = 18'h0ABCD;
        in_req = 1'b1;
        tick(12);
        chk("held_stall", 32'(stall0), 1);
        chk("held_cnt", 32'(cnt0), 32'(exp_cnt));
        chk("held_dout", dout0, last0);
        button = 1'b1;
        tick(10);
        chk("held_rel_stall", 32'(stall0), 1);
        push_exp(18'h0ABCD);
        button = 1'b0;
        tick(10);
        button = 1'b1;
        wait_valid(n);
        chk("held_lat", n, 6);
        tick(1);
        in_req = 1'b0;
        tick(2);
        chk("held_cnt_after", 32'(cnt0), 32'(exp_cnt));

        // Reset during WAIT_RELEASE
        switches = 18'h12345;
        tick(3);
        in_req = 1'b1;
        tick(1);
        button = 1'b0;
        tick(10);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", dout0, 0);
        chk("mid_rst_cnt", 32'(cnt0), 0);
        chk("mid_rst_stall", 32'(stall0), 0);
        chk("mid_rst_dv", 32'(dv0), 0);
        exp_cnt = 8'd0;
        last0 = 32'd0;
        last1 = 32'd0;
        tick(2);
        reset  = 1'b0;
        in_req = 1'b0;
        button = 1'b1;
        tick(20);
        chk("post_rst_cnt", 32'(cnt0), 0);

        // Abort from WAIT_PRESS
        in_req = 1'b1;
        tick(3);
        in_req = 1'b0;
        #1;
        chk("abort_stall", 32'(stall0), 0);
        tick(2);
        button = 1'b0;
        tick(10);
        button = 1'b1;
        tick(10);
        chk("abort_cnt", 32'(cnt0), 32'(exp_cnt));
        chk("abort_dout", dout0, last0);

        // Recovery
        do_txn(18'h00005, 18'h00005);
        chk("recov_cnt", 32'(cnt0), 1);

        tick(5);
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
